// File: rtl/mips_core_pkg.sv
// Shared core types and widths used by the stream buffer and its AXI read interfaces.
// The width macros are normally supplied by mips_core.svh; these defaults apply only when that header is absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

    localparam int ADDR_W    = `ADDR_WIDTH;
    localparam int DATA_W    = `DATA_WIDTH;
    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RECV  = 3'd2,
        FULL  = 3'd3,
        DRAIN = 3'd4
    } stream_buffer_state_t;

endpackage

// File: rtl/stream_buffer_if.sv
// AXI read-address and read-data channel bundles shared between the
// prefetch masters and the memory arbiter.
interface axi_read_address;
    import mips_core_pkg::*;

    logic                 ARVALID;
    logic                 ARREADY;
    logic [ADDR_W-1:0]    ARADDR;
    logic [AXI_LEN_W-1:0] ARLEN;
    logic [AXI_ID_W-1:0]  ARID;

    modport master (output ARVALID, ARADDR, ARLEN, ARID, input ARREADY);
    modport slave  (input ARVALID, ARADDR, ARLEN, ARID, output ARREADY);
endinterface

interface axi_read_data;
    import mips_core_pkg::*;

    logic                RVALID;
    logic                RREADY;
    logic [AXI_ID_W-1:0] RID;
    logic [DATA_W-1:0]   RDATA;
    logic                RLAST;

    modport master (input RVALID, RID, RDATA, RLAST, output RREADY);
    modport slave  (output RVALID, RID, RDATA, RLAST, input RREADY);
endinterface

// File: rtl/stream_buffer.sv
// Single-line sequential prefetch buffer: after an i-cache miss it fetches the
// next line over AXI and offers it as a hit if the following miss asks for it.
module stream_buffer
    import mips_core_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int SB_ID      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              miss_valid,
    input  logic [`ADDR_WIDTH-1:0]            miss_addr,
    output logic                              hit,
    output logic [LINE_WORDS*`DATA_WIDTH-1:0] hit_line,
    axi_read_address.master                   mem_read_address,
    axi_read_data.master                      mem_read_data
);

    localparam int                  CNT_W     = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0]   LINE_STEP = ADDR_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [AXI_ID_W-1:0] MY_ID     = AXI_ID_W'(SB_ID);

    stream_buffer_state_t state_q, state_d;
    logic [ADDR_W-1:0]    tag_q, tag_d;
    logic [ADDR_W-1:0]    pend_addr_q, pend_addr_d;
    logic                 pend_q, pend_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0] line_q, line_d;

    logic rready;
    logic beat;
    logic last_beat;

    assign rready    = (state_q == RECV) || (state_q == DRAIN);
    // Beats tagged for another master are left for their owner.
    assign beat      = rready && mem_read_data.RVALID && (mem_read_data.RID == MY_ID);
    assign last_beat = beat && (mem_read_data.RLAST || (cnt_q == LAST_CNT));

    assign hit      = (state_q == FULL) && miss_valid && (miss_addr == tag_q);
    assign hit_line = line_q;

    assign mem_read_address.ARVALID = (state_q == REQ);
    assign mem_read_address.ARADDR  = tag_q;
    assign mem_read_address.ARLEN   = AXI_LEN_W'(LINE_WORDS - 1);
    assign mem_read_address.ARID    = MY_ID;
    assign mem_read_data.RREADY     = rready;

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        pend_addr_d = pend_addr_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        line_d      = line_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    tag_d   = miss_addr + LINE_STEP;
                    state_d = REQ;
                end
            end
            REQ: begin
                // The request in flight must stay put; remember the redirect instead.
                if (miss_valid) begin
                    pend_addr_d = miss_addr;
                    pend_d      = 1'b1;
                end
                if (mem_read_address.ARREADY) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (beat) begin
                    line_d[cnt_q] = mem_read_data.RDATA;
                    cnt_d         = cnt_q + 1'b1;
                end
                if (miss_valid) begin
                    // A redirect landing on the final beat needs no drain.
                    if (last_beat) begin
                        tag_d   = miss_addr + LINE_STEP;
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        pend_addr_d = miss_addr;
                        pend_d      = 1'b1;
                        state_d     = DRAIN;
                    end
                end else if (last_beat) begin
                    if (pend_q) begin
                        tag_d   = pend_addr_q + LINE_STEP;
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        state_d = FULL;
                    end
                end
            end
            DRAIN: begin
                if (miss_valid) begin
                    pend_addr_d = miss_addr;
                end
                if (beat && mem_read_data.RLAST) begin
                    tag_d   = pend_addr_d + LINE_STEP;
                    pend_d  = 1'b0;
                    state_d = REQ;
                end
            end
            FULL: begin
                if (miss_valid) begin
                    tag_d   = (hit ? tag_q : miss_addr) + LINE_STEP;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
        end
    end

endmodule

// File: tb/tb_stream_buffer.sv
// Scoreboarded bench for stream_buffer: expected AR requests and hit lines are
// queued when stimulus is driven and checked when the DUT presents them.
module tb_stream_buffer;
    import mips_core_pkg::*;

    localparam int LW = 4;
    localparam int ID = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 miss_valid = 1'b0;
    logic [ADDR_W-1:0]    miss_addr = '0;
    logic                 hit;
    logic [LW*DATA_W-1:0] hit_line;

    axi_read_address ar_if ();
    axi_read_data    rd_if ();

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0]    exp_ar[$];
    logic [LW*DATA_W-1:0] exp_line[$];

    always #5 clk = ~clk;

    stream_buffer #(.LINE_WORDS(LW), .SB_ID(ID)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_valid       (miss_valid),
        .miss_addr        (miss_addr),
        .hit              (hit),
        .hit_line         (hit_line),
        .mem_read_address (ar_if),
        .mem_read_data    (rd_if)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] wd(input logic [ADDR_W-1:0] b, input int i);
        return DATA_W'({8'hA5, b[19:0], 4'(i)});
    endfunction

    function automatic logic [LW*DATA_W-1:0] line_of(input logic [ADDR_W-1:0] b);
        logic [LW*DATA_W-1:0] l;
        for (int i = 0; i < LW; i++) l[i*DATA_W +: DATA_W] = wd(b, i);
        return l;
    endfunction

    // One-cycle miss pulse; hit is checked combinationally before the edge.
    task automatic mv(input logic [ADDR_W-1:0] a, input logic exp_hit);
        miss_valid = 1'b1;
        miss_addr  = a;
        @(negedge clk);
        chk("hit", hit, exp_hit);
        if (exp_hit) begin
            chk("line_sb_nonempty", exp_line.size() > 0, 1);
            if (exp_line.size() > 0) chk("hit_line", hit_line, exp_line.pop_front());
        end
        cyc();
        miss_valid = 1'b0;
    endtask

    // Accept one AR request, optionally stalling ARREADY and injecting a miss mid-stall.
    task automatic ar_take(input int stall, input int mv_at, input logic [ADDR_W-1:0] mv_addr);
        int w = 0;
        logic [ADDR_W-1:0] e = '0;
        while (!ar_if.ARVALID) begin
            if (w == 20) begin
                chk("ar_timeout", ar_if.ARVALID, 1);
                return;
            end
            cyc();
            w++;
        end
        chk("ar_sb_nonempty", exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) e = exp_ar.pop_front();
        for (int i = 0; i < stall; i++) begin
            miss_valid = (i == mv_at);
            miss_addr  = mv_addr;
            @(negedge clk);
            chk("ar_stall_valid", ar_if.ARVALID, 1);
            chk("ar_stall_addr", ar_if.ARADDR, e);
            cyc();
        end
        miss_valid     = 1'b0;
        ar_if.ARREADY  = 1'b1;
        @(negedge clk);
        chk("arvalid", ar_if.ARVALID, 1);
        chk("araddr", ar_if.ARADDR, e);
        chk("arlen", ar_if.ARLEN, LW - 1);
        chk("arid", ar_if.ARID, ID);
        chk("rready_in_req", rd_if.RREADY, 0);
        cyc();
        ar_if.ARREADY = 1'b0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last, input int rid);
        rd_if.RVALID = 1'b1;
        rd_if.RID    = AXI_ID_W'(rid);
        rd_if.RDATA  = d;
        rd_if.RLAST  = last;
        @(negedge clk);
        chk("rready", rd_if.RREADY, 1);
        cyc();
        rd_if.RVALID = 1'b0;
        rd_if.RLAST  = 1'b0;
    endtask

    task automatic burst(input logic [ADDR_W-1:0] b, input bit push);
        for (int i = 0; i < LW; i++) beat(wd(b, i), i == LW - 1, ID);
        if (push) exp_line.push_back(line_of(b));
    endtask

    initial begin
        logic [ADDR_W-1:0] all1 = '1;

        ar_if.ARREADY = 1'b0;
        rd_if.RVALID  = 1'b0;
        rd_if.RID     = '0;
        rd_if.RDATA   = '0;
        rd_if.RLAST   = 1'b0;

        #2;
        chk("rst_arvalid", ar_if.ARVALID, 0);
        chk("rst_rready", rd_if.RREADY, 0);
        chk("rst_hit", hit, 0);
        chk("rst_line", hit_line, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Cold miss, then sequential hit continues the stream.
        exp_ar.push_back(ADDR_W'('h104));
        mv(ADDR_W'('h100), 1'b0);
        ar_take(0, -1, '0);
        burst(ADDR_W'('h104), 1'b1);
        exp_ar.push_back(ADDR_W'('h108));
        mv(ADDR_W'('h104), 1'b1);

        // Non-sequential miss while FULL.
        ar_take(0, -1, '0);
        burst(ADDR_W'('h108), 1'b0);
        exp_ar.push_back(ADDR_W'('h204));
        mv(ADDR_W'('h200), 1'b0);

        // Redirect after two beats; the rest of the burst is drained.
        ar_take(0, -1, '0);
        beat(wd(ADDR_W'('h204), 0), 1'b0, ID);
        beat(wd(ADDR_W'('h204), 1), 1'b0, ID);
        exp_ar.push_back(ADDR_W'('h304));
        mv(ADDR_W'('h300), 1'b0);
        beat(wd(ADDR_W'('h204), 2), 1'b0, ID);
        beat(wd(ADDR_W'('h204), 3), 1'b1, ID);
        ar_take(0, -1, '0);
        burst(ADDR_W'('h304), 1'b0);

        // Address wrap.
        exp_ar.push_back('0);
        mv(all1 - ADDR_W'(3), 1'b0);

        // Stalled ARREADY with a redirect pending during REQ.
        exp_ar.push_back(ADDR_W'('h404));
        ar_take(5, 2, ADDR_W'('h400));
        burst('0, 1'b0);
        ar_take(0, -1, '0);
        beat(wd(ADDR_W'('h404), 0), 1'b0, ID);
        beat(32'hDEAD_BEEF, 1'b1, 5);
        for (int i = 1; i < LW; i++) beat(wd(ADDR_W'('h404), i), i == LW - 1, ID);
        exp_line.push_back(line_of(ADDR_W'('h404)));
        exp_ar.push_back(ADDR_W'('h408));
        mv(ADDR_W'('h404), 1'b1);

        // Reset in the middle of a burst.
        ar_take(0, -1, '0);
        beat(wd(ADDR_W'('h408), 0), 1'b0, ID);
        beat(wd(ADDR_W'('h408), 1), 1'b0, ID);
        rd_if.RVALID = 1'b1;
        rd_if.RID    = AXI_ID_W'(ID);
        rd_if.RDATA  = wd(ADDR_W'('h408), 2);
        miss_valid   = 1'b1;
        miss_addr    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_arvalid", ar_if.ARVALID, 0);
        chk("midrst_rready", rd_if.RREADY, 0);
        chk("midrst_hit", hit, 0);
        chk("midrst_line", hit_line, 0);
        rd_if.RVALID = 1'b0;
        miss_valid   = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        exp_ar.push_back(ADDR_W'('h504));
        mv(ADDR_W'('h500), 1'b0);
        ar_take(0, -1, '0);
        burst(ADDR_W'('h504), 1'b1);
        exp_ar.push_back(ADDR_W'('h508));
        mv(ADDR_W'('h504), 1'b1);
        ar_take(0, -1, '0);

        chk("ar_sb_drained", exp_ar.size(), 0);
        chk("line_sb_drained", exp_line.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_buffer.md
STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per line; legal values 2..8.
REQ-002 Parameter SB_ID, default 2, AXI thread id driven on ARID; equals this master's arbiter slot.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port miss_valid  input  1  i_cache reports a line miss this cycle.
REQ-006 Port miss_addr  input  `ADDR_WIDTH  line-aligned word address of the missed line.
REQ-007 Port hit  output  1  buffered line matches miss_addr and is complete (combinational).
REQ-008 Port hit_line  output  LINE_WORDS*`DATA_WIDTH  buffered line; word 0 in the LSBs.
REQ-009 Port mem_read_address  axi_read_address.master  -  prefetch request toward the arbiter.
REQ-010 Port mem_read_data  axi_read_data.master  -  prefetch beats from the arbiter.

Function
REQ-011 States SHALL be IDLE, REQ, RECV, FULL, DRAIN.
REQ-012 IDLE: on miss_valid, tag <= miss_addr + LINE_WORDS (modulo 2^`ADDR_WIDTH), next state REQ.
REQ-013 REQ: ARVALID=1, ARADDR=tag, ARLEN=LINE_WORDS-1, ARID=SB_ID; payload held stable until ARREADY; on ARVALID&&ARREADY go RECV with beat counter=0.
REQ-014 RECV: RREADY=1; each RVALID beat writes RDATA into word[counter], counter+1; beat with RLAST (or counter==LINE_WORDS-1) goes FULL.
REQ-015 RLAST SHALL take precedence; no beat beyond LINE_WORDS is stored.
REQ-016 FULL: hit = miss_valid && miss_addr==tag; on hit, tag <= tag+LINE_WORDS, next state REQ (sequential stream continues).
REQ-017 FULL on miss_valid without match: tag <= miss_addr+LINE_WORDS, next state REQ.
REQ-018 hit SHALL be 0 in every state except FULL.
REQ-019 miss_valid in REQ: tag and ARADDR SHALL NOT change (AXI stability); request completes; the new address is latched into a pending register and pending flag set.
REQ-020 miss_valid in RECV: go DRAIN, latch pending address; remaining beats accepted and discarded.
REQ-021 DRAIN: RREADY=1; on RLAST beat, tag <= pending+LINE_WORDS, clear pending, next state REQ.
REQ-022 RECV->FULL with pending set SHALL instead go REQ with tag <= pending+LINE_WORDS.
REQ-023 Latest miss_valid overwrites the pending address (only one outstanding redirect).
REQ-024 At most one AXI read outstanding at any time.
REQ-025 RVALID with RID != SB_ID SHALL be ignored (not accepted, RREADY still per state).
REQ-026 RREADY SHALL be 0 in IDLE, REQ, FULL.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ARVALID=0, RREADY=0, hit=0, pending=0, counter=0, tag=0, line storage=0.
REQ-028 Reset mid-burst abandons the burst; memory system is reset together, so no drain is required.

Structure
REQ-029 State enum stream_buffer_state_t SHALL live in mips_core_pkg; `ADDR_WIDTH/`DATA_WIDTH from mips_core.svh.
REQ-030 No sub-module; line storage, counter and FSM in one module.

Verification
REQ-031 Cold miss: miss_addr=0x100 in IDLE -> ARADDR=0x104, ARLEN=3, ARID=2; 4 beats A..D -> FULL; miss_addr=0x104 -> hit=1, hit_line={D,C,B,A}, next ARADDR=0x108.
REQ-032 Non-sequential miss in FULL: tag 0x104, miss_addr=0x200 -> hit=0, next ARADDR=0x204.
REQ-033 Redirect during RECV after 2 beats, miss_addr=0x300 -> last 2 beats drained, no hit, next ARADDR=0x304.
REQ-034 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; miss_addr=0x400 during REQ -> after burst, ARADDR=0x404.
REQ-035 Wrap: miss_addr=all-ones minus 3 -> ARADDR=0.
REQ-036 rst_n low on beat 2 of RECV -> outputs zero same cycle; next miss restarts cleanly.
